d_swin: RTL and testbench
=========================

D_SWIN -- requirements
Module: d_swin

Interface
REQ-001 Parameter: DEB_DIV, default 50000, clock cycles per debounce tick (legal range 2..2^20).
REQ-002 Parameter: DEB_CNT, default 4, consecutive ticks an input must differ from its debounced state before that state updates (legal range 1..15).
REQ-003 Port: clk_i  input  1  system clock; all flops are rising-edge.
REQ-004 Port: rst_in  input  1  reset, asynchronous and active-low.
REQ-005 Port: sw_i  input  16  raw asynchronous switch/button levels, 1 = pressed.
REQ-006 Port: d_i  input  32  bus write data.
REQ-007 Port: wen_i  input  1  bus write strobe, sampled at the rising clock edge.
REQ-008 Port: be0_i, be1_i, be2_i, be3_i  input  1 each  byte-lane enables for d_i[7:0], [15:8], [23:16] and [31:24].
REQ-009 Port: d_rd_o  output  32  read data, {flag[15:0], state[15:0]}.
REQ-010 Port: irq_o  output  1  OR of all flag bits.

Function
REQ-011 Each sw_i bit SHALL pass through its own 2-flop synchronizer (sync1, sync2) before any other logic uses it.
REQ-012 The prescaler SHALL count 0..DEB_DIV-1 and wrap to 0.
REQ-013 tick SHALL be 1 for exactly the one cycle in which the prescaler equals DEB_DIV-1.
REQ-014 Each input i SHALL have a 4-bit counter cnt[i].
REQ-015 If sync2[i] == state[i], cnt[i] SHALL clear to 0 on that edge, regardless of tick.
REQ-016 If sync2[i] != state[i] and tick=1 and cnt[i] < DEB_CNT-1, cnt[i] SHALL increment.
REQ-017 If sync2[i] != state[i] and tick=1 and cnt[i] == DEB_CNT-1, state[i] SHALL load sync2[i] and cnt[i] SHALL clear to 0.
REQ-018 If sync2[i] != state[i] and tick=0, cnt[i] SHALL hold.
REQ-019 A glitch shorter than DEB_CNT ticks SHALL NOT change state[i].
REQ-020 state[i] SHALL update no earlier than 2 cycles plus DEB_CNT ticks after a stable change on sw_i[i].
REQ-021 flag[i] SHALL set on the same edge at which state[i] changes 0->1.
REQ-022 A 1->0 change of state[i] SHALL NOT affect flag[i].
REQ-023 On an edge with wen_i=1, flag bits 7:0 SHALL clear where d_i[23:16] bit = 1 and be2_i=1 (write-1-to-clear).
REQ-024 On an edge with wen_i=1, flag bits 15:8 SHALL clear where d_i[31:24] bit = 1 and be3_i=1 (write-1-to-clear).
REQ-025 Writes to lanes 0 and 1 SHALL have no effect (state is read-only).
REQ-026 If a set and a clear of flag[i] occur on the same edge, the set SHALL win and flag[i] stays 1.
REQ-027 Write data bits equal to 0 and disabled lanes SHALL leave their flags unchanged.
REQ-028 d_rd_o and irq_o SHALL be purely combinational from registered state and flags, with zero-cycle read latency.
REQ-029 Reads SHALL have no side effects.

Reset
REQ-030 While rst_in=0, sync1, sync2, prescaler, all cnt, state and flag SHALL be 0 (d_rd_o=0, irq_o=0), asynchronously to clk_i.
REQ-031 Reset asserted mid-count SHALL discard the partial debounce progress.
REQ-032 After rst_in rises, the prescaler SHALL restart from 0 on the first clock edge.
REQ-033 An input already held at 1 through reset SHALL be debounced normally after reset and set its flag.

Verification (DEB_DIV=4, DEB_CNT=3)
REQ-034 Reset: rst_in=0 with sw_i=16'hFFFF -> d_rd_o=0, irq_o=0 throughout.
REQ-035 Stable press: sw_i[0] 0->1 held -> state[0]=1 after 2 sync cycles plus 3 ticks (at most 14 cycles), flag[0]=1, d_rd_o=32'h0001_0001, irq_o=1.
REQ-036 Glitch: sw_i[3]=1 for 6 cycles, then 0 -> state[3] and flag[3] stay 0.
REQ-037 W1C with lanes: flags=16'h8001; write d_i=32'hFFFF_FFFF, be2_i=1, be3_i=0 -> flags=16'h8000.
REQ-038 W1C with lanes: then write d_i=32'h8000_0000, be3_i=1 -> flags=0, irq_o=0.
REQ-039 Collision and release: clear flag[5] on the same edge state[5] rises -> flag[5]=1; then release sw_i[5] -> state[5]=0 after 3 ticks, flag[5] still 1.
REQ-040 Reset mid-operation: assert rst_in after 2 of 3 ticks with sw_i[1]=1 -> all outputs 0; after release, a full 2 cycles plus 3 ticks are needed before state[1]=1.

Source files
------------

// File: rtl/d_swin.sv
// Switch input debouncer: 16 synchronized and debounced levels plus
// sticky rising-edge flags with write-1-to-clear and an interrupt.
module d_swin #(
  parameter int DEB_DIV = 50000,
  parameter int DEB_CNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [15:0] sw_i,
  input  logic [31:0] d_i,
  input  logic        wen_i,
  input  logic        be0_i,
  input  logic        be1_i,
  input  logic        be2_i,
  input  logic        be3_i,
  output logic [31:0] d_rd_o,
  output logic        irq_o
);

  localparam int PW = $clog2(DEB_DIV);
  localparam logic [PW-1:0] PMAX = PW'(DEB_DIV - 1);
  localparam logic [3:0] CMAX = 4'(DEB_CNT - 1);

  logic [15:0]   sync1;
  logic [15:0]   sync2;
  logic [PW-1:0] pre;
  logic          tick;
  logic [3:0]    cnt [16];
  logic [3:0]    cnt_nxt [16];
  logic [15:0]   state;
  logic [15:0]   state_nxt;
  logic [15:0]   flag;
  logic [15:0]   flag_nxt;
  logic [15:0]   rise;
  logic [15:0]   clr;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_i;
      sync2 <= sync1;
    end
  end

  assign tick = (pre == PMAX);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A bit only moves once its input has disagreed for DEB_CNT ticks in a row.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    for (int i = 0; i < 16; i++) begin
      if (sync2[i] == state[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CMAX) begin
          state_nxt[i] = sync2[i];
          cnt_nxt[i]   = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + 4'd1;
        end
      end
    end
  end

  assign rise = state_nxt & ~state;

  always_comb begin
    clr = '0;
    if (wen_i) begin
      clr = {d_i[31:24] & {8{be3_i}},
             d_i[23:16] & {8{be2_i}}};
    end
  end

  // Set beats clear when both land on the same edge.
  assign flag_nxt = (flag & ~clr) | rise;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state <= '0;
      flag  <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      flag  <= flag_nxt;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign d_rd_o = {flag, state};
  assign irq_o  = |flag;

endmodule

// File: tb/tb_d_swin.sv
// Randomized and directed bench for d_swin against a
// tick-counting reference model.
module tb_d_swin;

  localparam int DD = 4;
  localparam int DC = 3;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic [15:0] sw_i = '0;
  logic [31:0] d_i = '0;
  logic        wen_i = 1'b0;
  logic        be0_i = 1'b0;
  logic        be1_i = 1'b0;
  logic        be2_i = 1'b0;
  logic        be3_i = 1'b0;
  logic [31:0] d_rd_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  d_swin #(
    .DEB_DIV(DD),
    .DEB_CNT(DC)
  ) dut (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .sw_i  (sw_i),
    .d_i   (d_i),
    .wen_i (wen_i),
    .be0_i (be0_i),
    .be1_i (be1_i),
    .be2_i (be2_i),
    .be3_i (be3_i),
    .d_rd_o(d_rd_o),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: input seen two edges late; a bit follows its
  // input after DC consecutive ticks of disagreement.
  logic [15:0] m_sync1 = '0;
  logic [15:0] m_sync2 = '0;
  logic [15:0] m_state = '0;
  logic [15:0] m_flag = '0;
  int          m_run [16];
  int          m_edges = 0;

  task automatic m_clear();
    m_sync1 = '0;
    m_sync2 = '0;
    m_state = '0;
    m_flag  = '0;
    m_edges = 0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
  endtask

  task automatic m_step();
    logic        t;
    logic [15:0] ns;
    logic [15:0] cl;
    t  = ((m_edges % DD) == DD - 1);
    ns = m_state;
    for (int i = 0; i < 16; i++) begin
      if (m_sync2[i] == m_state[i]) m_run[i] = 0;
      else if (t) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DC) begin
          ns[i] = m_sync2[i];
          m_run[i] = 0;
        end
      end
    end
    cl = '0;
    if (wen_i) begin
      if (be2_i) cl[7:0]  = d_i[23:16];
      if (be3_i) cl[15:8] = d_i[31:24];
    end
    m_flag  = (m_flag & ~cl) | (ns & ~m_state);
    m_state = ns;
    m_sync2 = m_sync1;
    m_sync1 = sw_i;
    m_edges++;
  endtask

  initial m_clear();
  always @(negedge rst_in) m_clear();
  always @(posedge clk_i) begin
    if (!rst_in) m_clear();
    else m_step();
  end

  always @(negedge clk_i) begin
    #2;
    chk("rd", d_rd_o, {m_flag, m_state});
    chk("irq", {31'b0, irq_o}, {31'b0, |m_flag});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wr(input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    wen_i = 1'b1;
    d_i = d;
    {be3_i, be2_i, be1_i, be0_i} = be;
    @(negedge clk_i);
    wen_i = 1'b0;
    {be3_i, be2_i, be1_i, be0_i} = '0;
  endtask

  task automatic wait_bit(input int b, input logic v,
                          input int lim, output int n);
    n = 0;
    while (d_rd_o[b] !== v && n < lim) begin
      @(negedge clk_i);
      #1;
      n++;
    end
  endtask

  int  n;
  bit  found;

  initial begin
    sw_i = 16'hFFFF;
    rst_in = 1'b0;
    cyc(1);
    #1;
    chk("rst_rd", d_rd_o, 32'h0);
    chk("rst_irq", {31'b0, irq_o}, 32'h0);
    cyc(5);
    #1;
    chk("rst_rd_hold", d_rd_o, 32'h0);
    sw_i = '0;
    cyc(1);
    rst_in = 1'b1;
    cyc(3);

    sw_i[0] = 1'b1;
    wait_bit(0, 1'b1, 20, n);
    chk("press_lat_ok", {31'b0, (n >= 11 && n <= 14)}, 32'h1);
    chk("press_rd", d_rd_o, 32'h0001_0001);
    chk("press_irq", {31'b0, irq_o}, 32'h1);

    @(negedge clk_i);
    sw_i[3] = 1'b1;
    cyc(6);
    sw_i[3] = 1'b0;
    cyc(20);
    #1;
    chk("glitch_st", {31'b0, d_rd_o[3]}, 32'h0);
    chk("glitch_fl", {31'b0, d_rd_o[19]}, 32'h0);

    sw_i[15] = 1'b1;
    wait_bit(15, 1'b1, 20, n);
    chk("w1c_pre", {16'h0, d_rd_o[31:16]}, 32'h8001);
    wr(32'hFFFF_FFFF, 4'b0111);
    #1;
    chk("w1c_lane2", {16'h0, d_rd_o[31:16]}, 32'h8000);
    chk("w1c_ro_state", {16'h0, d_rd_o[15:0]}, 32'h8001);
    wr(32'h8000_0000, 4'b1000);
    #1;
    chk("w1c_lane3", {16'h0, d_rd_o[31:16]}, 32'h0);
    chk("w1c_irq", {31'b0, irq_o}, 32'h0);

    sw_i[5] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_i);
      if (m_sync2[5] && !m_state[5] && m_run[5] == DC - 1 &&
          (m_edges % DD) == DD - 1) begin
        found = 1'b1;
        wen_i = 1'b1;
        d_i = 32'h0020_0000;
        be2_i = 1'b1;
      end
    end
    @(negedge clk_i);
    wen_i = 1'b0;
    be2_i = 1'b0;
    #1;
    chk("coll_found", {31'b0, found}, 32'h1);
    chk("coll_st", {31'b0, d_rd_o[5]}, 32'h1);
    chk("coll_fl", {31'b0, d_rd_o[21]}, 32'h1);
    sw_i[5] = 1'b0;
    cyc(20);
    #1;
    chk("rel_st", {31'b0, d_rd_o[5]}, 32'h0);
    chk("rel_fl", {31'b0, d_rd_o[21]}, 32'h1);

    wr(32'hFFFF_0000, 4'b1100);
    sw_i[1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk_i);
      if (m_run[1] == 2) found = 1'b1;
    end
    chk("mid_found", {31'b0, found}, 32'h1);
    rst_in = 1'b0;
    #1;
    chk("mid_rst_rd", d_rd_o, 32'h0);
    chk("mid_rst_irq", {31'b0, irq_o}, 32'h0);
    cyc(3);
    rst_in = 1'b1;
    wait_bit(1, 1'b1, 30, n);
    chk("mid_rst_lat", n, 32'd12);
    chk("mid_rst_fl", {31'b0, d_rd_o[17]}, 32'h1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 19) == 0) sw_i[i] = ~sw_i[i];
      end
      wen_i = ($urandom_range(0, 5) == 0);
      d_i = $urandom;
      {be3_i, be2_i, be1_i, be0_i} = 4'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        rst_in = 1'b0;
        cyc($urandom_range(1, 3));
        rst_in = 1'b1;
      end
    end
    wen_i = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
